// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between the instruction-fetch and data-access requesters.
// Optional macro ARB_RR_EN: round-robin arbitration instead of fixed data-over-inst priority.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_DATA} grant_t;

  state_t state;
  grant_t grant;
  logic   pick_inst;
  logic   pick_data;
  logic   resp_ok;

`ifdef ARB_RR_EN
  logic   last_data;
`endif

  // Winner selection; only meaningful while idle and out of reset.
  always_comb begin
    pick_inst = 1'b0;
    pick_data = 1'b0;
    if (resetn && (state == IDLE)) begin
`ifdef ARB_RR_EN
      if (inst_req && data_req) begin
        pick_data = ~last_data;
        pick_inst = last_data;
      end else begin
        pick_data = data_req;
        pick_inst = inst_req;
      end
`else
      pick_data = data_req;
      pick_inst = inst_req & ~data_req;
`endif
    end
  end

  assign inst_addr_ok = pick_inst;
  assign data_addr_ok = pick_data;

  // Response is routed to whoever holds the grant; the other side reads zero.
  assign resp_ok      = (state == WAIT) && mem_data_ok;
  assign inst_data_ok = resp_ok && (grant == GNT_INST);
  assign data_data_ok = resp_ok && (grant == GNT_DATA);
  assign inst_rdata   = (grant == GNT_INST) ? mem_rdata : '0;
  assign data_rdata   = (grant == GNT_DATA) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      last_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_data) begin
            mem_req   <= 1'b1;
            mem_wr    <= data_wr;
            mem_size  <= data_size;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            grant     <= GNT_DATA;
            state     <= REQ;
`ifdef ARB_RR_EN
            last_data <= 1'b1;
`endif
          end else if (pick_inst) begin
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_size  <= SIZE_WORD;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
            grant     <= GNT_INST;
            state     <= REQ;
`ifdef ARB_RR_EN
            last_data <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_data_ok) begin
            grant <= GNT_NONE;
            state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          grant   <= GNT_NONE;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Drives the memory side through a minimum-latency completion of the granted request.
  task automatic finish_txn();
    next_cycle(); idle_inputs(); mem_addr_ok = 1'b1;
    next_cycle(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = $urandom;
    next_cycle(); mem_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, mem_wr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, mem_wr});
    end
    checks++;
    if ({mem_size, mem_addr, mem_wdata, inst_rdata, data_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_buses got size=%0d addr=%h wdata=%h irdata=%h drdata=%h want all 0",
               mem_size, mem_addr, mem_wdata, inst_rdata, data_rdata);
    end
    idle_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_single_fetch();
    next_cycle(); inst_req = 1'b1; inst_addr = 32'h1FC0_0000; settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_accept got %b want 100", {inst_addr_ok, data_addr_ok, mem_req});
    end
    next_cycle(); inst_req = 1'b0; inst_addr = 32'hDEAD_0000; mem_addr_ok = 1'b1; settle();
    checks++;
    if ({mem_req, mem_wr, mem_size, mem_addr, inst_addr_ok} !== {1'b1, 1'b0, 2'd2, 32'h1FC0_0000, 1'b0}) begin
      errors++;
      $display("FAIL fetch_issue got req=%b wr=%b size=%0d addr=%h want 1 0 2 1fc00000",
               mem_req, mem_wr, mem_size, mem_addr);
    end
    next_cycle(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; settle();
    checks++;
    if ({mem_req, inst_data_ok, data_data_ok} !== 3'b010) begin
      errors++; $display("FAIL fetch_resp got %b want 010", {mem_req, inst_data_ok, data_data_ok});
    end
    checks++;
    if ({inst_rdata, data_rdata} !== {32'h2408_0001, 32'h0}) begin
      errors++; $display("FAIL fetch_rdata got %h/%h want 24080001/00000000", inst_rdata, data_rdata);
    end
    next_cycle(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h1FC0_0004; settle();
    checks++;
    if ({inst_data_ok, inst_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL fetch_next_accept got %b want 01", {inst_data_ok, inst_addr_ok});
    end
    finish_txn();
  endtask

  task automatic test_store();
    next_cycle();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h4; data_wdata = 32'hAB;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL store_accept got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); data_req = 1'b0; data_wdata = $urandom; data_addr = $urandom;
      mem_addr_ok = (k == 2); settle();
      checks++;
      if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'd0, 32'h4, 32'hAB}) begin
        errors++;
        $display("FAIL store_hold[%0d] got req=%b wr=%b size=%0d addr=%h wdata=%h want 1 1 0 4 ab",
                 k, mem_req, mem_wr, mem_size, mem_addr, mem_wdata);
      end
    end
    next_cycle(); mem_addr_ok = 1'b0; settle();
    checks++;
    if ({mem_req, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL store_wait got %b want 00", {mem_req, data_data_ok});
    end
    next_cycle(); mem_data_ok = 1'b1; mem_rdata = 32'h55; settle();
    checks++;
    if ({data_data_ok, inst_data_ok, inst_addr_ok, inst_rdata, data_rdata} !== {3'b100, 32'h0, 32'h55}) begin
      errors++;
      $display("FAIL store_done got dok=%b iok=%b iaok=%b irdata=%h drdata=%h want 1 0 0 0 55",
               data_data_ok, inst_data_ok, inst_addr_ok, inst_rdata, data_rdata);
    end
    next_cycle(); mem_data_ok = 1'b0; settle();
    checks++;
    if (data_data_ok !== 1'b0) begin
      errors++; $display("FAIL store_single_pulse got %b want 0", data_data_ok);
    end
  endtask

  task automatic test_conflict();
    logic [1:0] exp3;
`ifdef ARB_RR_EN
    exp3 = 2'b10;
`else
    exp3 = 2'b01;
`endif
    do_reset();
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h200;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL conflict1 got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    next_cycle(); data_req = 1'b0; mem_addr_ok = 1'b1; settle();
    checks++;
    if ({inst_addr_ok, mem_addr} !== {1'b0, 32'h200}) begin
      errors++; $display("FAIL conflict1_issue got aok=%b addr=%h want 0 200", inst_addr_ok, mem_addr);
    end
    next_cycle(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; settle();
    checks++;
    if ({data_data_ok, inst_addr_ok, data_rdata} !== {2'b10, 32'h1111_2222}) begin
      errors++; $display("FAIL conflict1_resp got dok=%b iaok=%b rdata=%h want 1 0 11112222",
                         data_data_ok, inst_addr_ok, data_rdata);
    end
    next_cycle(); mem_data_ok = 1'b0; settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b100) begin
      errors++; $display("FAIL conflict1_inst_next got %b want 100", {inst_addr_ok, data_addr_ok, mem_req});
    end
    finish_txn();
    next_cycle(); inst_req = 1'b1; data_req = 1'b1; settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL conflict2 got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    finish_txn();
    next_cycle(); inst_req = 1'b1; data_req = 1'b1; settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== exp3) begin
      errors++; $display("FAIL conflict3 got %b want %b", {inst_addr_ok, data_addr_ok}, exp3);
    end
    finish_txn();
  endtask

  task automatic test_stall();
    int pulses = 0;
    next_cycle(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h3000; settle();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL stall_accept got %b want 1", data_addr_ok);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle(); data_req = 1'b0; data_addr = $urandom;
      mem_addr_ok = (k == 5); mem_data_ok = (k == 2); settle();
      pulses += int'(data_data_ok) + int'(inst_data_ok);
      checks++;
      if ({mem_req, mem_size, mem_addr} !== {1'b1, 2'd1, 32'h3000}) begin
        errors++; $display("FAIL stall_req[%0d] got req=%b size=%0d addr=%h want 1 1 3000",
                           k, mem_req, mem_size, mem_addr);
      end
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(); mem_addr_ok = 1'b0; mem_data_ok = (k == 3); mem_rdata = 32'hCAFE; settle();
      pulses += int'(data_data_ok) + int'(inst_data_ok);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL stall_wait_req[%0d] got %b want 0", k, mem_req);
      end
    end
    next_cycle(); mem_data_ok = 1'b0; settle();
    pulses += int'(data_data_ok) + int'(inst_data_ok);
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL stall_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_stray();
    next_cycle(); idle_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF; settle();
    checks++;
    if ({inst_data_ok, data_data_ok, mem_req, inst_rdata, data_rdata} !== '0) begin
      errors++; $display("FAIL stray_resp got iok=%b dok=%b req=%b irdata=%h drdata=%h want all 0",
                         inst_data_ok, data_data_ok, mem_req, inst_rdata, data_rdata);
    end
    next_cycle(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h40; settle();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL stray_still_idle got %b want 1", inst_addr_ok);
    end
    finish_txn();
  endtask

  task automatic test_reset_wait();
    next_cycle(); inst_req = 1'b1; inst_addr = 32'h80; settle();
    next_cycle(); inst_req = 1'b0; mem_addr_ok = 1'b1; settle();
    next_cycle(); mem_addr_ok = 1'b0; resetn = 1'b0; settle();
    checks++;
    if ({inst_data_ok, data_data_ok, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_rdata} !== '0) begin
      errors++; $display("FAIL rstwait_outputs got req=%b addr=%h irdata=%h iok=%b want all 0",
                         mem_req, mem_addr, inst_rdata, inst_data_ok);
    end
    next_cycle(); resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1234;
    inst_req = 1'b1; inst_addr = 32'h90; settle();
    checks++;
    if ({inst_data_ok, data_data_ok, inst_addr_ok, inst_rdata} !== {3'b001, 32'h0}) begin
      errors++; $display("FAIL rstwait_release got iok=%b dok=%b iaok=%b irdata=%h want 0 0 1 0",
                         inst_data_ok, data_data_ok, inst_addr_ok, inst_rdata);
    end
    next_cycle(); inst_req = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b1; settle();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h90}) begin
      errors++; $display("FAIL rstwait_issue got req=%b addr=%h want 1 90", mem_req, mem_addr);
    end
    next_cycle(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5678; settle();
    checks++;
    if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h5678}) begin
      errors++; $display("FAIL rstwait_resp got iok=%b rdata=%h want 1 5678", inst_data_ok, inst_rdata);
    end
    next_cycle(); mem_data_ok = 1'b0;
  endtask

  // Randomized traffic: requesters hold until accepted, memory answers with random latency.
  task automatic test_random();
    bit busy = 1'b0, issuing = 1'b0, resp_wait = 1'b0, last_data = 1'b0;
    int resp_cnt = 0;
    bit t_data = 1'b0, t_wr = 1'b0;
    logic [1:0]  t_size = 2'd0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    bit i_pend = 1'b0, d_pend = 1'b0, d_w = 1'b0;
    logic [31:0] i_a = '0, d_a = '0, d_wd = '0;
    logic [1:0]  d_s = 2'd0;
    bit a_ok, stray, win_i, win_d, resp_now;
    logic [31:0] rd;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      if (!i_pend && $urandom_range(2) == 0) begin i_pend = 1'b1; i_a = $urandom; end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1'b1; d_a = $urandom; d_wd = $urandom;
        d_w = 1'($urandom_range(1)); d_s = 2'($urandom_range(2));
      end
      inst_req   = i_pend;
      inst_addr  = i_pend ? i_a : $urandom;
      data_req   = d_pend;
      data_wr    = d_pend ? d_w : 1'($urandom);
      data_size  = d_pend ? d_s : 2'($urandom);
      data_addr  = d_pend ? d_a : $urandom;
      data_wdata = d_pend ? d_wd : $urandom;
      resp_now = resp_wait && (resp_cnt == 0);
      a_ok     = issuing && ($urandom_range(2) != 0);
      stray    = !resp_wait && !a_ok && ($urandom_range(7) == 0);
      rd = $urandom;
      mem_addr_ok = a_ok; mem_data_ok = resp_now || stray; mem_rdata = rd;
      settle();

      win_i = 1'b0; win_d = 1'b0;
      if (!busy) begin
        if (i_pend && d_pend) begin
`ifdef ARB_RR_EN
          if (last_data) win_i = 1'b1; else win_d = 1'b1;
`else
          win_d = 1'b1;
`endif
        end else begin
          win_i = i_pend; win_d = d_pend;
        end
      end
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== {win_i, win_d}) begin
        errors++; $display("FAIL rnd_grant cyc %0d got %b want %b", cyc,
                           {inst_addr_ok, data_addr_ok}, {win_i, win_d});
      end
      checks++;
      if (mem_req !== issuing) begin
        errors++; $display("FAIL rnd_mem_req cyc %0d got %b want %b", cyc, mem_req, issuing);
      end
      if (issuing) begin
        checks++;
        if ({mem_wr, mem_size, mem_addr} !== {t_wr, t_size, t_addr} ||
            (t_data && mem_wdata !== t_wdata)) begin
          errors++; $display("FAIL rnd_mem_fields cyc %0d got %b %0d %h %h want %b %0d %h %h", cyc,
                             mem_wr, mem_size, mem_addr, mem_wdata, t_wr, t_size, t_addr, t_wdata);
        end
      end
      checks++;
      if ({inst_data_ok, data_data_ok} !== {resp_now && !t_data, resp_now && t_data}) begin
        errors++; $display("FAIL rnd_data_ok cyc %0d got %b want %b", cyc, {inst_data_ok, data_data_ok},
                           {resp_now && !t_data, resp_now && t_data});
      end
      if (resp_now) begin
        checks++;
        if ({inst_rdata, data_rdata} !== (t_data ? {32'h0, rd} : {rd, 32'h0})) begin
          errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h rd %h data_side %b", cyc,
                             inst_rdata, data_rdata, rd, t_data);
        end
      end

      if (resp_now) begin
        busy = 1'b0; resp_wait = 1'b0;
      end else if (resp_wait) begin
        resp_cnt--;
      end
      if (issuing && a_ok) begin
        issuing = 1'b0; resp_wait = 1'b1; resp_cnt = int'($urandom_range(3));
      end
      if (win_d) begin
        busy = 1'b1; issuing = 1'b1; t_data = 1'b1; t_wr = d_w; t_size = d_s;
        t_addr = d_a; t_wdata = d_wd; d_pend = 1'b0; last_data = 1'b1;
      end else if (win_i) begin
        busy = 1'b1; issuing = 1'b1; t_data = 1'b0; t_wr = 1'b0; t_size = 2'd2;
        t_addr = i_a; t_wdata = '0; i_pend = 1'b0; last_data = 1'b0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_stall();
    test_stray();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
